// File: rtl/imul_var_pkg.sv
// ---------------------------------------------------------------
// imul_var_pkg : shared state encoding and sizing helpers for the
//                variable-latency iterative multiplier.  Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package imul_var_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // count must represent NBITS itself, hence one bit beyond log2
  function automatic int cnt_w(input int nbits);
    return $clog2(nbits) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/imul_tzc.sv
// ---------------------------------------------------------------
// imul_tzc : trailing-zero count of b, saturated at MAX_SHAMT
//            (b == 0 reports MAX_SHAMT).  Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module imul_tzc
  import imul_var_pkg::*;
#(
  parameter int NBITS     = 32,
  parameter int MAX_SHAMT = 4
) (
  input  logic [NBITS-1:0]        b,
  output logic [cnt_w(NBITS)-1:0] tz
);

  localparam int CW = cnt_w(NBITS);

  // Scan high to low so the lowest set bit wins
  always_comb begin
    tz = CW'(MAX_SHAMT);
    for (int i = MAX_SHAMT - 1; i >= 0; i--) begin
      if (b[i]) tz = CW'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/imul_int_mul_var.sv
// ---------------------------------------------------------------
// imul_int_mul_var : variable-latency shift-add multiplier that skips
//   zero runs of b; optional IMUL_EARLY_EXIT_EN stops once b==0.  Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module imul_int_mul_var
  import imul_var_pkg::*;
#(
  parameter int NBITS     = 32,
  parameter int MAX_SHAMT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               istream_val,
  output logic               istream_rdy,
  input  logic [2*NBITS-1:0] istream_msg,
  output logic               ostream_val,
  input  logic               ostream_rdy,
  output logic [NBITS-1:0]   ostream_msg
);

  localparam int CW = cnt_w(NBITS);

  state_e           state;
  state_e           state_next;
  logic [NBITS-1:0] a_reg;
  logic [NBITS-1:0] b_reg;
  logic [NBITS-1:0] result_reg;
  logic [CW-1:0]    count_reg;

  logic [CW-1:0]    tz;
  logic [CW-1:0]    remaining;
  logic [CW-1:0]    shamt;
  logic [CW-1:0]    count_next;
  logic             calc_last;
  logic             b_zero;

  imul_tzc #(
    .NBITS     (NBITS),
    .MAX_SHAMT (MAX_SHAMT)
  ) u_tzc (
    .b  (b_reg),
    .tz (tz)
  );

  // Clamp the skip so count lands exactly on NBITS
  always_comb begin
    remaining  = CW'(NBITS) - count_reg;
    shamt      = b_reg[0] ? CW'(1) : ((tz < remaining) ? tz : remaining);
    count_next = count_reg + shamt;
    calc_last  = (count_next == CW'(NBITS));
  end

`ifdef IMUL_EARLY_EXIT_EN
  assign b_zero = (b_reg == '0);
`else
  assign b_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    istream_rdy = 1'b0;
    ostream_val = 1'b0;
    case (state)
      IDLE: begin
        istream_rdy = 1'b1;
        if (istream_val) state_next = CALC;
      end
      CALC: begin
        if (b_zero || calc_last) state_next = DONE;
      end
      DONE: begin
        ostream_val = 1'b1;
        if (ostream_rdy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      count_reg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (istream_val) begin
            a_reg      <= istream_msg[2*NBITS-1:NBITS];
            b_reg      <= istream_msg[NBITS-1:0];
            result_reg <= '0;
            count_reg  <= '0;
          end
        end
        CALC: begin
          if (!b_zero) begin
            if (b_reg[0]) result_reg <= result_reg + a_reg;
            a_reg     <= a_reg << shamt;
            b_reg     <= b_reg >> shamt;
            count_reg <= count_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign ostream_msg = result_reg;

endmodule

`default_nettype wire
